// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, add/sub opcode encoding and
// the {Cout, V, Z} flag bundle consumed by the condition-code register.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Field order gives the packed bundle {Cout, V, Z}.
  typedef struct packed {
    logic cout;
    logic v;
    logic z;
  } alu_flags_t;

endpackage

// File: rtl/alu_add_pipe_if.sv
// Operand/result handshake bundle between the ALU operand muxes, the pipelined
// adder and the result register. Signal names follow the datapath (Ra/Rb/S).
interface alu_add_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Ra;
  logic [WIDTH-1:0] Rb;
  logic             Cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;
  logic             Z;

  modport master (
    output in_valid, Ra, Rb, Cin, op_sub, out_ready,
    input  in_ready, out_valid, S, Cout, V, Z
  );

  modport slave (
    input  in_valid, Ra, Rb, Cin, op_sub, out_ready,
    output in_ready, out_valid, S, Cout, V, Z
  );
endinterface

// File: rtl/add_slice.sv
// Combinational SW-bit ripple-carry adder: one pipeline slice of alu_add_pipe.
module add_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout
);

  logic [SW:0] c;

  // NOTE: every output of a combinational block gets a default before any
  // conditional or looped assignment, so no path can leave it unassigned and
  // infer a latch.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SW; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SW];
  end

endmodule

// File: rtl/alu_add_pipe.sv
// Skewed add/subtract pipeline: one SW-bit slice resolves per stage with the
// carry registered between slices; a single global stall freezes every stage.
module alu_add_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_add_pipe_if.slave  bus
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;

  logic [STAGES-1:0][SW-1:0]    sl_a, sl_b, sl_s;
  logic [STAGES-1:0]            sl_cin, sl_cout;

  logic [WIDTH-1:0] b_in;
  logic             stall;
  alu_flags_t       flags;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    add_slice #(.SW(SW)) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (sl_cin[k]),
      .s    (sl_s[k]),
      .cout (sl_cout[k])
    );
  end

  // B' is formed once at capture; op_sub is not carried down the pipe.
  always_comb begin
    b_in      = (bus.op_sub == OP_SUB) ? ~bus.Rb : bus.Rb;
    sl_a      = '0;
    sl_b      = '0;
    sl_cin    = '0;
    sl_a[0]   = bus.Ra[SW-1:0];
    sl_b[0]   = b_in[SW-1:0];
    sl_cin[0] = (bus.op_sub == OP_SUB) ? 1'b1 : bus.Cin;
    for (int k = 1; k < STAGES; k++) begin
      sl_a[k]   = a_q[k-1][k*SW +: SW];
      sl_b[k]   = b_q[k-1][k*SW +: SW];
      sl_cin[k] = c_q[k-1];
    end
  end

  // Stage k inherits the lower sums from stage k-1 and patches in slice k.
  always_comb begin
    valid_d = valid_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    if (!stall) begin
      valid_d[0]         = bus.in_valid;
      a_d[0]             = bus.Ra;
      b_d[0]             = b_in;
      s_d[0]             = '0;
      s_d[0][SW-1:0]     = sl_s[0];
      c_d[0]             = sl_cout[0];
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k]          = valid_q[k-1];
        a_d[k]              = a_q[k-1];
        b_d[k]              = b_q[k-1];
        s_d[k]              = s_q[k-1];
        s_d[k][k*SW +: SW]  = sl_s[k];
        c_d[k]              = sl_cout[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
    end
  end

  // Z is qualified by valid so the cleared datapath does not read as zero.
  always_comb begin
    stall         = valid_q[LAST] && !bus.out_ready;
    flags.cout    = c_q[LAST];
    flags.v       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                    (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    flags.z       = valid_q[LAST] && (s_q[LAST] == '0);
    bus.in_ready  = !stall;
    bus.out_valid = valid_q[LAST];
    bus.S         = s_q[LAST];
    {bus.Cout, bus.V, bus.Z} = flags;
  end

endmodule
